// File: rtl/counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : counter_bank
// Purpose  : Bank of independent up/down counters sharing a runtime modulus,
//            with per-channel terminal-count pulse and a registered readout.
// Revision : 1.0
// ============================================================================
module counter_bank #(
    parameter int          nbits     = 32,
    parameter int          nch       = 8,
    parameter int          selbits   = 3,
    parameter int unsigned increment = 1,
    parameter bit          wrap      = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [nch-1:0]         count_clear,
    input  logic [nch-1:0]         count_load,
    input  logic [nbits-1:0]       load_data,
    input  logic [nch-1:0]         count_en,
    input  logic [nch-1:0]         count_dn,
    input  logic [nbits-1:0]       count_max,
    input  logic [selbits-1:0]     rd_sel,
    output logic [nbits-1:0]       rd_out,
    output logic [nch*nbits-1:0]   count_out,
    output logic [nch-1:0]         count_tc
);

    // One extra bit so value + increment never overflows the comparison.
    localparam logic [nbits:0] c_inc = (nbits+1)'(increment);

    logic [nbits-1:0] r_cnt  [nch];
    logic [nch-1:0]   r_tc;
    logic [nbits-1:0] r_rd;

    logic [nbits:0]   w_sum  [nch];
    logic [nbits-1:0] w_diff [nch];
    logic [nbits-1:0] w_next [nch];
    logic [nch-1:0]   w_bnd;
    logic [nbits-1:0] w_load;

    assign w_load = (load_data > count_max) ? count_max : load_data;

    always_comb begin
        w_bnd = '0;
        for (int i = 0; i < nch; i++) begin
            w_sum[i]  = {1'b0, r_cnt[i]} + c_inc;
            w_diff[i] = r_cnt[i] - c_inc[nbits-1:0];
            w_next[i] = r_cnt[i];
            if (count_dn[i]) begin
                w_bnd[i] = ({1'b0, r_cnt[i]} < c_inc);
                if (w_bnd[i])
                    w_next[i] = wrap ? count_max : '0;
                else if (w_diff[i] > count_max)
                    w_next[i] = count_max;
                else
                    w_next[i] = w_diff[i];
            end else begin
                w_bnd[i] = (w_sum[i] > {1'b0, count_max});
                if (w_bnd[i])
                    w_next[i] = wrap ? '0 : count_max;
                else
                    w_next[i] = w_sum[i][nbits-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < nch; i++)
                r_cnt[i] <= '0;
            r_tc <= '0;
            r_rd <= '0;
        end else begin
            for (int i = 0; i < nch; i++) begin
                if (count_clear[i]) begin
                    r_cnt[i] <= '0;
                    r_tc[i]  <= 1'b0;
                end else if (count_load[i]) begin
                    r_cnt[i] <= w_load;
                    r_tc[i]  <= 1'b0;
                end else if (count_en[i]) begin
                    r_cnt[i] <= w_next[i];
                    r_tc[i]  <= w_bnd[i];
                end else begin
                    r_tc[i]  <= 1'b0;
                end
            end
            // Readout samples the pre-edge register; out-of-range selects read 0.
            r_rd <= (int'(rd_sel) < nch) ? r_cnt[rd_sel] : '0;
        end
    end

    generate
        for (genvar g = 0; g < nch; g++) begin : g_pack
            assign count_out[g*nbits +: nbits] = r_cnt[g];
        end
    endgenerate

    assign count_tc = r_tc;
    assign rd_out   = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_bank
// Purpose  : Scoreboard bench for counter_bank; three parameterisations share
//            one stimulus stream and a behavioural reference model.
// Revision : 1.0
// ============================================================================
module tb_counter_bank;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  count_clear = '0, count_load = '0, count_en = '0, count_dn = '0;
    logic [31:0] load_data = '0, count_max = '0;
    logic [2:0]  rd_sel = '0;

    logic [255:0] co0;
    logic [63:0]  co1;
    logic [47:0]  co2;
    logic [7:0]   tc0, tc1;
    logic [5:0]   tc2;
    logic [31:0]  rd0;
    logic [7:0]   rd1, rd2;

    always #5 clk = ~clk;

    counter_bank #(.nbits(32), .nch(8), .selbits(3), .increment(1), .wrap(1'b1)) u0 (
        .clk(clk), .reset(reset), .count_clear(count_clear), .count_load(count_load),
        .load_data(load_data), .count_en(count_en), .count_dn(count_dn),
        .count_max(count_max), .rd_sel(rd_sel), .rd_out(rd0), .count_out(co0),
        .count_tc(tc0));

    counter_bank #(.nbits(8), .nch(8), .selbits(3), .increment(3), .wrap(1'b1)) u1 (
        .clk(clk), .reset(reset), .count_clear(count_clear), .count_load(count_load),
        .load_data(load_data[7:0]), .count_en(count_en), .count_dn(count_dn),
        .count_max(count_max[7:0]), .rd_sel(rd_sel), .rd_out(rd1), .count_out(co1),
        .count_tc(tc1));

    counter_bank #(.nbits(8), .nch(6), .selbits(3), .increment(1), .wrap(1'b0)) u2 (
        .clk(clk), .reset(reset), .count_clear(count_clear[5:0]),
        .count_load(count_load[5:0]), .load_data(load_data[7:0]),
        .count_en(count_en[5:0]), .count_dn(count_dn[5:0]),
        .count_max(count_max[7:0]), .rd_sel(rd_sel), .rd_out(rd2), .count_out(co2),
        .count_tc(tc2));

    typedef struct packed {
        logic [255:0] c0;
        logic [63:0]  c1;
        logic [47:0]  c2;
        logic [7:0]   t0;
        logic [7:0]   t1;
        logic [5:0]   t2;
        logic [31:0]  r0;
        logic [7:0]   r1;
        logic [7:0]   r2;
    } exp_t;

    exp_t   q[$];
    event   sample_ev;
    int     n_tests = 0;
    int     n_fail  = 0;

    longint m_cnt [3][8];
    bit     m_tc  [3][8];
    longint m_rd  [3];

    function automatic int nb_f(input int d);  return (d == 0) ? 32 : 8; endfunction
    function automatic int nc_f(input int d);  return (d == 2) ? 6 : 8;  endfunction
    function automatic longint inc_f(input int d); return (d == 1) ? 3 : 1; endfunction
    function automatic bit wr_f(input int d);  return (d != 2);         endfunction

    task automatic model_zero();
        for (int d = 0; d < 3; d++) begin
            m_rd[d] = 0;
            for (int c = 0; c < 8; c++) begin
                m_cnt[d][c] = 0;
                m_tc[d][c]  = 1'b0;
            end
        end
    endtask

    // Next state of every counter from the rules, using wide integer arithmetic.
    task automatic model_step();
        longint mask, mx, ld, v, inc;
        int     sel;
        for (int d = 0; d < 3; d++) begin
            mask = (longint'(1) << nb_f(d)) - 1;
            mx   = longint'(count_max) & mask;
            ld   = longint'(load_data) & mask;
            inc  = inc_f(d);
            sel  = int'(rd_sel);
            m_rd[d] = (sel < nc_f(d)) ? m_cnt[d][sel] : 0;
            for (int c = 0; c < nc_f(d); c++) begin
                v = m_cnt[d][c];
                m_tc[d][c] = 1'b0;
                if (count_clear[c]) begin
                    v = 0;
                end else if (count_load[c]) begin
                    v = (ld > mx) ? mx : ld;
                end else if (count_en[c]) begin
                    if (!count_dn[c]) begin
                        if (v + inc > mx) begin
                            v = wr_f(d) ? 0 : mx;
                            m_tc[d][c] = 1'b1;
                        end else begin
                            v = v + inc;
                        end
                    end else begin
                        if (v < inc) begin
                            v = wr_f(d) ? mx : 0;
                            m_tc[d][c] = 1'b1;
                        end else begin
                            v = v - inc;
                            if (v > mx) v = mx;
                        end
                    end
                end
                m_cnt[d][c] = v;
            end
        end
    endtask

    function automatic exp_t build_exp();
        exp_t e;
        e = '0;
        for (int c = 0; c < 8; c++) begin
            e.c0[c*32 +: 32] = m_cnt[0][c][31:0];
            e.c1[c*8 +: 8]   = m_cnt[1][c][7:0];
            e.t0[c]          = m_tc[0][c];
            e.t1[c]          = m_tc[1][c];
        end
        for (int c = 0; c < 6; c++) begin
            e.c2[c*8 +: 8] = m_cnt[2][c][7:0];
            e.t2[c]        = m_tc[2][c];
        end
        e.r0 = m_rd[0][31:0];
        e.r1 = m_rd[1][7:0];
        e.r2 = m_rd[2][7:0];
        return e;
    endfunction

    task automatic tick();
        model_step();
        q.push_back(build_exp());
        @(posedge clk);
        #1;
    endtask

    // Assert reset between edges and expect all outputs cleared before the next edge.
    task automatic async_reset();
        @(negedge clk);
        #1;
        reset = 1'b1;
        model_zero();
        q.push_back(build_exp());
        #1;
        ->sample_ev;
        #1;
        reset = 1'b0;
    endtask

    task automatic check(input string nm, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk or sample_ev);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("count_out0", 256'(co0), 256'(e.c0));
                check("count_out1", 256'(co1), 256'(e.c1));
                check("count_out2", 256'(co2), 256'(e.c2));
                check("count_tc0",  256'(tc0), 256'(e.t0));
                check("count_tc1",  256'(tc1), 256'(e.t1));
                check("count_tc2",  256'(tc2), 256'(e.t2));
                check("rd_out0",    256'(rd0), 256'(e.r0));
                check("rd_out1",    256'(rd1), 256'(e.r1));
                check("rd_out2",    256'(rd2), 256'(e.r2));
            end
        end
    end

    initial begin
        model_zero();
        async_reset();

        // Reset in the middle of counting, then resume from zero.
        count_max = 100;
        count_en  = 8'hFF;
        repeat (5) tick();
        async_reset();
        repeat (3) tick();

        // Wrap-up sequence 0,3,6,9,0 on the increment-3 bank.
        count_en = '0; count_clear = 8'hFF; count_max = 10;
        tick();
        count_clear = '0; count_en = 8'h01;
        repeat (5) tick();

        // Saturating down count from 2.
        count_en = '0; count_load = 8'h01; load_data = 2;
        tick();
        count_load = '0; count_en = 8'h01; count_dn = 8'h01;
        repeat (4) tick();
        count_en = '0; count_dn = '0;
        tick();

        // Clear beats load beats enable; load clamps to the ceiling.
        count_clear = 8'h04; count_load = 8'h04; count_en = 8'h04; load_data = 77;
        count_max = 1000;
        tick();
        count_clear = '0; count_en = '0; load_data = 500; count_max = 200;
        tick();
        count_load = '0;

        // Lowered ceiling: up step wraps, down step clamps.
        count_max = 100; count_load = 8'h02; load_data = 50;
        tick();
        count_load = '0; count_max = 20; count_en = 8'h02;
        tick();
        count_en = '0; count_max = 100; count_load = 8'h02;
        tick();
        count_load = '0; count_max = 20; count_en = 8'h02; count_dn = 8'h02;
        tick();
        count_en = '0; count_dn = '0;

        // Readout sweep over distinct channel values 10..17.
        count_max = 1000;
        for (int i = 0; i < 8; i++) begin
            count_load = 8'(1 << i);
            load_data  = 32'(10 + i);
            tick();
        end
        count_load = '0;
        for (int i = 0; i < 8; i++) begin
            rd_sel = 3'(i);
            tick();
        end
        tick();

        // Randomised traffic with occasional extreme ceilings and resets.
        for (int k = 0; k < 400; k++) begin
            count_clear = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'h00;
            count_load  = ($urandom_range(0, 7) == 0)  ? 8'($urandom) : 8'h00;
            count_en    = 8'($urandom);
            count_dn    = 8'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 4))
                    0:       count_max = 0;
                    1:       count_max = 32'hFFFF_FFFF;
                    2:       count_max = $urandom_range(0, 20);
                    3:       count_max = $urandom;
                    default: count_max = 32'h0000_00FF;
                endcase
            end
            case ($urandom_range(0, 3))
                0:       load_data = $urandom;
                1:       load_data = 32'hFFFF_FFFF;
                2:       load_data = $urandom_range(0, 30);
                default: load_data = 32'hFFFF_FFFE;
            endcase
            rd_sel = 3'($urandom);
            if ($urandom_range(0, 99) == 0)
                async_reset();
            else
                tick();
        end

        @(negedge clk);
        #1;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/counter_bank.md
# counter_bank

Bank of `nch` independent, parametrised up/down counters with a shared runtime modulus, wrap or saturate mode, and a registered terminal-count pulse per channel. It also provides a registered single-channel readout port. It succeeds the single fixed-increment counter plus external mux8 readout in the pageRank datapath, and is used for per-node/per-iteration bookkeeping. Everything here is sequential on one clock.

## Interface
Parameters:
- `nbits`, 32, width of each counter.
- `nch`, 8, number of channels; legal range is 1 to 2^`selbits`.
- `selbits`, 3, width of `rd_sel`.
- `increment`, 1, step size for both up and down counts; legal range is 1 to 2^`nbits`-1.
- `wrap`, 1, boundary mode: 1 = wrap, 0 = saturate.

Ports (clock and reset first):
- `clk`, input, 1, sole clock; all state updates on the rising edge.
- `reset`, input, 1, asynchronous, active-high.
- `count_clear`, input, `nch`, per-channel synchronous clear.
- `count_load`, input, `nch`, per-channel synchronous load of `load_data`.
- `load_data`, input, `nbits`, shared load value.
- `count_en`, input, `nch`, per-channel step enable.
- `count_dn`, input, `nch`, per-channel direction: 0 = up, 1 = down.
- `count_max`, input, `nbits`, shared modulus ceiling; sampled every cycle.
- `rd_sel`, input, `selbits`, readout channel index.
- `rd_out`, output, `nbits`, registered value of the selected channel.
- `count_out`, output, `nch*nbits`, all counter registers; channel i occupies bits [i*nbits +: nbits].
- `count_tc`, output, `nch`, registered terminal-count pulse.

## Operation
- Reset value of every output is 0: all counters, `rd_out` and `count_tc`.
- Per-channel update priority at each edge is clear > load > enable > hold.
- Clear sets the counter to 0. `count_tc` for that channel is 0.
- Load sets the counter to min(`load_data`, `count_max`), i.e. load clamps. `count_tc` is 0.
- Up step, non-boundary case: when value + `increment` <= `count_max`, the new value is value + `increment`.
  - Compare in `nbits`+1 bits so no overflow occurs.
  - This rule also applies when value > `count_max` (after `count_max` is lowered): the step is then a boundary.
- Up step, boundary case (value + `increment` > `count_max`): counter wraps to 0 if `wrap`=1, or saturates to `count_max` if `wrap`=0.
- Down step, non-boundary case: when value >= `increment`, the new value is value − `increment`.
  - If that result would exceed `count_max`, it is clamped to `count_max`.
- Down step, boundary case (value < `increment`): counter wraps to `count_max` if `wrap`=1, or saturates to 0 if `wrap`=0.
- `count_tc[i]` is 1 in the cycle after any enabled step on channel i that hit a boundary.
  - In saturate mode it stays high on every cycle the step is re-attempted at the boundary.
  - It is 0 otherwise.
- `count_max` = 0: every up or down step is a boundary, so the counter stays at 0 and `count_tc` pulses on each enabled step.
- Readout: `rd_out` <= counter[`rd_sel`] (the pre-edge register value). If `rd_sel` >= `nch`, `rd_out` <= 0.
- Channels are fully independent. Simultaneous operations on different channels never interact.

## Timing
- Counter update latency: inputs sampled at edge N, new value visible on `count_out` after edge N.
- `count_out` is a direct register view with no added combinational logic.
- `count_tc` has 1-cycle latency and is aligned with the updated counter value on `count_out`.
- `rd_out` is 1 cycle behind the register it selects; it is 2 cycles behind the inputs that caused an update.
- `reset` assertion clears all state immediately, without waiting for an edge, including mid-count and mid-load.
- The first edge after `reset` deasserts operates normally.
- No handshake exists: every enabled request is serviced in the cycle it is sampled, and no backpressure is applied.

## Test plan
- Reset mid-count: all 8 channels counting up with `count_max`=100; assert `reset` asynchronously between edges.
  - Required: `count_out`, `rd_out` and `count_tc` go to 0 before the next edge.
  - Required: counting resumes from 0 after deassert.
- Wrap up, `increment`=3, `count_max`=10, `wrap`=1: channel 0 goes 0→3→6→9→0.
  - Required: `count_tc[0]` high for exactly the one cycle after the 9→0 step.
- Saturate down, `wrap`=0, `increment`=1: load 2, then enable down for 4 cycles.
  - Required sequence: 2→1→0→0→0.
  - Required: `count_tc` is high on the last two cycles.
- Priority: same cycle `count_clear[2]`=1, `count_load[2]`=1, `count_en[2]`=1 → channel 2 becomes 0.
  - Next, load 500 with `count_max`=200 → channel 2 becomes 200.
- Lowered ceiling: channel 1 at 50; set `count_max`=20.
  - Up step with `wrap`=1 → 0 with `tc`=1.
  - Separately, from 50, a down step (`increment`=1) → 20.
- Readout: channels hold distinct values 10..17.
  - Sweep `rd_sel` 0..7; required: `rd_out` = 10..17, each one cycle after its select.
  - `rd_sel`=7 with `nch`=6 → `rd_out`=0.
